// File: rtl/ab_seq_pkg.sv
// ---------------------------------------------------------------------------
// ab_seq_pkg -- shared definitions for the A/B sequence driver and any bench
// that drives or observes the two-input detector.
//   state_t : controller states IDLE, RUN, DRAIN, DONE
//   step_t  : stored step word {a, b, exp_y}, with a in bit 2
//   IDLE_A / IDLE_B : pattern held on a/b whenever no step is being replayed
// ---------------------------------------------------------------------------
package ab_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bit positions of the fields inside a 3-bit step word.
    localparam int STEP_A_BIT = 2;
    localparam int STEP_B_BIT = 1;
    localparam int STEP_Y_BIT = 0;

    typedef struct packed {
        logic a;
        logic b;
        logic exp_y;
    } step_t;

    // Detector idle-hold pattern.
    localparam logic IDLE_A = 1'b0;
    localparam logic IDLE_B = 1'b1;

endpackage

// File: rtl/ab_seq_mem.sv
// ---------------------------------------------------------------------------
// ab_seq_mem -- DEPTH x 3 step register file.
//   Clk   : clock
//   we    : write enable (already qualified by the controller)
//   waddr : write step index
//   wdata : step word written on posedge Clk when we=1
//   raddr : read step index
//   rdata : combinational read of the addressed step word
// ---------------------------------------------------------------------------
module ab_seq_mem
    import ab_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          Clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  step_t         wdata,
    input  logic [AW-1:0] raddr,
    output step_t         rdata
);

    step_t mem [DEPTH];

    // NOTE: storage has no reset on purpose; contents survive Rst so a
    // sequence loaded once can be replayed after an aborted run.
    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ab_seq_driver.sv
// ---------------------------------------------------------------------------
// ab_seq_driver -- replays a stored {a, b, exp_y} sequence into a registered
// two-input detector and checks the detector's y against exp_y.
//   Clk, Rst         : clock, synchronous active-low reset
//   wr_en/addr/data  : load one step word (accepted in IDLE or DONE only)
//   len, start       : start a replay of steps 0..len-1 (len legal 1..DEPTH)
//   a, b             : registered stimulus to the detector
//   y                : detector's registered response
//   busy, done       : run in progress / one-cycle end-of-run pulse
//   mismatch         : sticky failure flag for the current run
//   err_count        : saturating count of failed compares in the current run
//
// Timing: a step word read in RUN cycle k is registered onto a/b and its
// exp_y enters pipeline stage 0 at the same edge. The detector samples a/b
// one edge later while stage 0 moves to stage 1, and y is compared against
// stage 1 on the following edge. Two DRAIN cycles therefore retire the last
// step exactly.
// ---------------------------------------------------------------------------
module ab_seq_driver
    import ab_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [2:0]    wr_data,
    input  logic [AW:0]   len,
    input  logic          start,
    output logic          a,
    output logic          b,
    input  logic          y,
    output logic          busy,
    output logic          done,
    output logic          mismatch,
    output logic [AW:0]   err_count
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state, state_nxt;
    logic [AW-1:0] idx;
    logic [AW:0]   len_q;
    step_t         rd_step;
    logic          s0_vld, s0_exp;
    logic          s1_vld, s1_exp;
    logic          len_ok, start_ok, last_step, wr_ok;

    assign len_ok    = (len != '0) && (len <= DEPTH_W);
    assign start_ok  = start && len_ok && (state == ST_IDLE);
    assign last_step = ({1'b0, idx} == (len_q - 1'b1));
    // Writes are blocked while a run is replaying the memory.
    assign wr_ok     = wr_en && ((state == ST_IDLE) || (state == ST_DONE));

    ab_seq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .Clk   (Clk),
        .we    (wr_ok),
        .waddr (wr_addr),
        .wdata (step_t'(wr_data)),
        .raddr (idx),
        .rdata (rd_step)
    );

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_ok) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_step) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                // Stage 0 empty means only the final compare remains.
                if (!s0_vld) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            len_q     <= '0;
            a         <= IDLE_A;
            b         <= IDLE_B;
            s0_vld    <= 1'b0;
            s0_exp    <= 1'b0;
            s1_vld    <= 1'b0;
            s1_exp    <= 1'b0;
            mismatch  <= 1'b0;
            err_count <= '0;
        end else begin
            state  <= state_nxt;
            s1_vld <= s0_vld;
            s1_exp <= s0_exp;
            s0_vld <= 1'b0;
            a      <= IDLE_A;
            b      <= IDLE_B;

            if (s1_vld && (y != s1_exp)) begin
                mismatch <= 1'b1;
                if (err_count != '1) err_count <= err_count + 1'b1;
            end

            unique case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        len_q     <= len;
                        idx       <= '0;
                        mismatch  <= 1'b0;
                        err_count <= '0;
                    end
                end
                ST_RUN: begin
                    a      <= rd_step.a;
                    b      <= rd_step.b;
                    s0_vld <= 1'b1;
                    s0_exp <= rd_step.exp_y;
                    idx    <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ab_seq_driver.sv
// ---------------------------------------------------------------------------
// tb_ab_seq_driver -- scoreboard bench for ab_seq_driver (DEPTH=8).
// A behavioural detector drives y: y registers b & ~(a & previous a). The
// reference model walks the stored words as a list, predicts the detector's
// answer per step and counts exp_y disagreements; each accepted start pushes
// its prediction and a monitor pops it when done pulses.
// ---------------------------------------------------------------------------
module tb_ab_seq_driver;
    import ab_seq_pkg::*;

    localparam int DEPTH   = 8;
    localparam int AW      = 3;
    localparam int ERR_MAX = (1 << (AW + 1)) - 1;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [2:0]    wr_data = '0;
    logic [AW:0]   len = '0;
    logic          start = 1'b0;
    logic          y;
    logic          a, b, busy, done, mismatch;
    logic [AW:0]   err_count;

    always #5 Clk = ~Clk;

    ab_seq_driver #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .len       (len),
        .start     (start),
        .a         (a),
        .b         (b),
        .y         (y),
        .busy      (busy),
        .done      (done),
        .mismatch  (mismatch),
        .err_count (err_count)
    );

    // Far-end detector: registered, remembers the previous a.
    logic det_pa;
    always @(posedge Clk) begin
        if (!Rst) begin
            det_pa <= 1'b0;
            y      <= 1'b0;
        end else begin
            y      <= b & ~(a & det_pa);
            det_pa <= a;
        end
    end

    typedef struct {
        int n;
        int errs;
        bit mm;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [2:0] mem_m [DEPTH];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         busy_run = 0;

    task automatic check(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Prediction for a replay of steps 0..n-1 of the model memory.
    function automatic exp_t model(int n);
        exp_t e;
        bit   pa = 1'b0;
        bit   resp;
        e.n    = n;
        e.errs = 0;
        for (int i = 0; i < n; i++) begin
            resp = mem_m[i][STEP_B_BIT] & ~(mem_m[i][STEP_A_BIT] & pa);
            pa   = mem_m[i][STEP_A_BIT];
            if (resp != mem_m[i][STEP_Y_BIT]) e.errs++;
        end
        if (e.errs > ERR_MAX) e.errs = ERR_MAX;
        e.mm = (e.errs != 0);
        return e;
    endfunction

    // Monitor: counts busy cycles and checks results when done pulses.
    always @(negedge Clk) begin
        if (!Rst) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("busy_cycles", busy_run, mon_e.n + 2);
                    check("err_count", int'(err_count), mon_e.errs);
                    check("mismatch", int'(mismatch), int'(mon_e.mm));
                    check("busy_at_done", int'(busy), 0);
                    check("idle_ab_at_done", int'({a, b}), int'({IDLE_A, IDLE_B}));
                end
                busy_run = 0;
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_step(int addr, logic [2:0] w);
        wr_en   = 1'b1;
        wr_addr = addr[AW-1:0];
        wr_data = w;
        mem_m[addr] = w;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0) begin
            check("done_seen", 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic run_seq(int n);
        len   = n[AW:0];
        start = 1'b1;
        exp_q.push_back(model(n));
        tick();
        start = 1'b0;
        wait_done();
    endtask

    logic [2:0] w;
    bit         pa;
    bit         resp;

    initial begin
        // Reset state.
        tick();
        tick();
        check("rst_a", int'(a), 0);
        check("rst_b", int'(b), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_mismatch", int'(mismatch), 0);
        check("rst_err_count", int'(err_count), 0);
        Rst = 1'b1;
        tick();

        // Reference sequence: all compares pass.
        write_step(0, 3'b011);
        write_step(1, 3'b111);
        write_step(2, 3'b110);
        write_step(3, 3'b000);
        for (int i = 4; i < DEPTH; i++) write_step(i, 3'($urandom));
        run_seq(4);

        // Step 2 exp_y flipped: exactly one failure, held after done.
        write_step(2, 3'b111);
        run_seq(4);
        repeat (3) tick();
        check("hold_mismatch", int'(mismatch), 1);
        check("hold_err_count", int'(err_count), 1);

        // Single-step run.
        run_seq(1);

        // Illegal lengths are ignored.
        len = '0; start = 1'b1; tick();
        len = 4'd9; tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("illegal_len_busy", int'(busy), 0);
            tick();
        end

        // Start and write while busy are ignored.
        for (int i = 0; i < DEPTH; i++) write_step(i, 3'($urandom));
        len = 4'd8; start = 1'b1;
        exp_q.push_back(model(8));
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; len = 4'd2;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = mem_m[1] ^ 3'b001;
        tick();
        start = 1'b0; wr_en = 1'b0;
        wait_done();
        run_seq(8);

        // Reset during the third RUN cycle aborts without done.
        len = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        Rst = 1'b0;
        exp_q.delete();
        tick();
        check("abort_a", int'(a), 0);
        check("abort_b", int'(b), 1);
        check("abort_busy", int'(busy), 0);
        Rst = 1'b1;
        repeat (3) begin
            check("abort_no_done", int'(done), 0);
            tick();
        end
        run_seq(8);

        // Every step fails: err_count reaches 8.
        pa = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w    = 3'($urandom);
            resp = w[STEP_B_BIT] & ~(w[STEP_A_BIT] & pa);
            pa   = w[STEP_A_BIT];
            w[STEP_Y_BIT] = ~resp;
            write_step(i, w);
        end
        run_seq(8);
        check("all_fail_err_count", int'(err_count), 8);

        // Randomized runs, some with a write in the start cycle.
        for (int it = 0; it < 12; it++) begin
            for (int j = 0; j < 3; j++) write_step(int'($urandom_range(DEPTH - 1)), 3'($urandom));
            if (it % 3 == 0) begin
                wr_en = 1'b1; wr_addr = '0; wr_data = 3'($urandom);
                mem_m[0] = wr_data;
            end
            run_seq(int'($urandom_range(DEPTH, 1)));
            wr_en = 1'b0;
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ab_seq_driver.md
AB_SEQ_DRIVER -- requirements
Module: ab_seq_driver

Interface
REQ-001 Parameter DEPTH, default 8, meaning number of stored steps; legal range 2..16, power of two.
REQ-002 Parameter AW, default 3, meaning address width; AW SHALL equal log2(DEPTH).
REQ-003 Clk  input  1  sole clock; all logic updates on posedge Clk.
REQ-004 Rst  input  1  synchronous, active-low reset (asserted when 0, sampled on posedge Clk).
REQ-005 wr_en  input  1  writes one step into sequence memory when high in IDLE or DONE.
REQ-006 wr_addr  input  AW  step index written.
REQ-007 wr_data  input  3  step word {a, b, exp_y}, bit 2 = a.
REQ-008 len  input  AW+1  number of steps to replay; sampled at start; legal 1..DEPTH.
REQ-009 start  input  1  single-cycle request to begin replay.
REQ-010 a, b  output  1 each  registered stimulus to the 2-input Mealy-style detector on the far end.
REQ-011 y  input  1  detector's registered output, returned for checking.
REQ-012 busy  output  1  high from the cycle after accepted start until the final compare.
REQ-013 done  output  1  one-cycle pulse after the final compare.
REQ-014 mismatch  output  1  sticky; set on any failed compare in the current run.
REQ-015 err_count  output  AW+1  number of failed compares in the current run, saturating at all-ones.

Function
REQ-016 States SHALL be IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: start=1 with legal len SHALL latch len, clear mismatch and err_count, set step index to 0, and go to RUN.
REQ-018 start with len=0 or len>DEPTH SHALL be ignored; the block stays in IDLE and busy stays 0.
REQ-019 RUN: each cycle SHALL drive {a,b} from memory[index] and increment index; after step len-1 is driven, the block SHALL go to DRAIN.
REQ-020 Compare latency: the exp_y of the step driven in cycle k SHALL be compared with y sampled at the end of cycle k+1, because the far end registers y one edge after sampling a,b.
REQ-021 A compare pipeline of 2 stages (valid bit + exp_y) SHALL carry expectations.
REQ-022 DRAIN: a=0 and b=1 SHALL be driven (detector idle-hold pattern); the block SHALL remain in DRAIN until the last pending compare retires, which is exactly 2 cycles.
REQ-023 DONE: done=1 for exactly one cycle; busy=0; the block returns to IDLE next cycle; mismatch and err_count SHALL hold until the next accepted start.
REQ-024 start while busy SHALL be ignored.
REQ-025 wr_en while busy SHALL be ignored; memory contents SHALL be unchanged.
REQ-026 wr_en and an accepted start in the same IDLE cycle: the write SHALL complete, and the run SHALL use the updated word.
REQ-027 err_count SHALL saturate rather than wrap; mismatch SHALL be set on the first failure.
REQ-028 len=1 SHALL produce RUN for 1 cycle, DRAIN for 2 cycles, then DONE.

Reset
REQ-029 On Rst=0 at posedge Clk: state=IDLE, a=0, b=1, busy=0, done=0, mismatch=0, err_count=0, index=0, and pipeline valids cleared.
REQ-030 Reset mid-run SHALL abort immediately with no done pulse; memory contents SHALL be retained (not reset).

Structure
REQ-031 The state encoding (IDLE..DONE), the step-word bit positions and the idle pattern SHALL be placed in a shared package, ab_seq_pkg, for reuse by the detector bench.
REQ-032 Sequence storage SHALL be a sub-module, ab_seq_mem: a DEPTH x 3 register file with one synchronous write port and one combinational read port.

Verification
REQ-033 Load {a,b,exp_y} = {0,1,1},{1,1,1},{1,1,0},{0,0,0}, len=4, start, with a detector attached -> busy for 6 cycles, done pulse, mismatch=0, err_count=0.
REQ-034 Same sequence with step 2 exp_y flipped to 1 -> mismatch=1, err_count=1 at done.
REQ-035 len=0 start, then len=9 (DEPTH=8) start -> no busy, no done, state stays IDLE.
REQ-036 Start and wr_en issued mid-run -> no restart, memory word unchanged when read back by a second run.
REQ-037 Rst=0 during the 3rd RUN cycle -> next cycle a=0, b=1, busy=0, no done; a fresh start replays the stored sequence correctly.
REQ-038 DEPTH=16, all 16 exp_y inverted -> err_count saturates at 31? no: err_count=16 (5 bits, no saturation), mismatch=1; DEPTH=8 with 8 failures -> err_count=8.
